// File: rtl/sregs_mc_pkg.sv
// Shared constants for the sregs_mc special-register block:
// register select map, MODE bit positions and the IRQ FSM states.
package sregs_pkg;

    localparam int SR_MODE      = 1;
    localparam int SR_BOOT      = 2;
    localparam int SR_IRQPC     = 3;
    localparam int SR_FLAGS     = 4;
    localparam int SR_MASK      = 5;
    localparam int SR_PEND      = 6;
    localparam int SR_DEPTH     = 7;
    localparam int SR_PAGE_BASE = 16;

    localparam int MODE_SUP     = 0;
    localparam int MODE_INA     = 1;
    localparam int MODE_IRQEN   = 2;
    localparam int MODE_PAGEOFF = 3;
    localparam int MODE_W       = 4;
    localparam int FLAGS_W      = 5;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_TAKE
    } irq_state_e;

    function automatic int vec_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sregs_mc_if.sv
// Bus bundle between sregs_mc and the decoder / PC unit.
// slave is the register block, master is its environment.
interface sregs_mc_if #(
    parameter int DATA_W = 16,
    parameter int PHYS_W = 20,
    parameter int IRQ_N  = 4
);
    import sregs_pkg::*;

    localparam int VEC_W = vec_w(IRQ_N);

    logic                sr_ie;
    logic [DATA_W-1:0]   sr_sel;
    logic [DATA_W-1:0]   sr_in;
    logic [DATA_W-1:0]   sr_out;
    logic                boot_commit;
    logic [IRQ_N-1:0]    irq_in;
    logic [DATA_W-1:0]   pc_in;
    logic                pc_ie;
    logic                pc_inc;
    logic                irq_take;
    logic [VEC_W-1:0]    irq_vec;
    logic                irq_ret;
    logic [DATA_W-1:0]   ret_pc;
    logic                boot_mode;
    logic                instr_mem_over;
    logic                irq_en;
    logic [FLAGS_W-1:0]  alu_flags_in;
    logic                alu_flags_ie;
    logic [FLAGS_W-1:0]  alu_flags;
    logic [DATA_W-1:0]   addr_in;
    logic [PHYS_W-1:0]   addr_out;

    modport slave (
        input  sr_ie, sr_sel, sr_in, boot_commit,
        input  irq_in, pc_in, pc_ie, pc_inc, irq_ret,
        input  alu_flags_in, alu_flags_ie, addr_in,
        output sr_out, irq_take, irq_vec, ret_pc,
        output boot_mode, instr_mem_over, irq_en,
        output alu_flags, addr_out
    );

    modport master (
        output sr_ie, sr_sel, sr_in, boot_commit,
        output irq_in, pc_in, pc_ie, pc_inc, irq_ret,
        output alu_flags_in, alu_flags_ie, addr_in,
        input  sr_out, irq_take, irq_vec, ret_pc,
        input  boot_mode, instr_mem_over, irq_en,
        input  alu_flags, addr_out
    );

endinterface

// File: rtl/sregs_mc_irq_ctl.sv
// Interrupt controller: edge-latched pending bits, fixed priority
// (line 0 first), take/return FSM and the nested saved-PC stack.
module irq_ctl
    import sregs_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IRQ_N      = 4,
    parameter int NEST_DEPTH = 2,
    parameter int VEC_W      = 2,
    parameter int DEP_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IRQ_N-1:0]  irq_i,
    input  logic [IRQ_N-1:0]  mask_i,
    input  logic [IRQ_N-1:0]  clr_i,
    input  logic              ien_i,
    input  logic              sup_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              pc_ie_i,
    input  logic              pc_inc_i,
    input  logic [DATA_W-1:0] tgt_i,
    input  logic              ret_i,
    input  logic              tos_we_i,
    output logic [IRQ_N-1:0]  pend_o,
    output logic [DEP_W-1:0]  depth_o,
    output logic [DATA_W-1:0] ret_pc_o,
    output logic              take_o,
    output logic [VEC_W-1:0]  vec_o,
    output logic              pop_o,
    output logic              pop_sup_o,
    output logic              pop_ien_o
);

    irq_state_e        state_q, state_d;
    logic [IRQ_N-1:0]  prev_q;
    logic [IRQ_N-1:0]  pend_q, pend_d;
    logic [IRQ_N-1:0]  req;
    logic [IRQ_N-1:0]  clr;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [VEC_W-1:0]  pick;
    logic [DEP_W-1:0]  depth_q, depth_d;
    logic [DATA_W-1:0] spc_q [NEST_DEPTH];
    logic [DATA_W-1:0] spc_d [NEST_DEPTH];
    logic [NEST_DEPTH-1:0] ssup_q, ssup_d;
    logic [NEST_DEPTH-1:0] sien_q, sien_d;
    logic [DATA_W-1:0] push_pc;
    logic [DATA_W-1:0] top_pc;
    logic              top_sup;
    logic              top_ien;
    logic              take;
    logic              pop;

    assign req = pend_q & mask_i;

    // lowest enabled pending index wins
    always_comb begin
        pick = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (req[i]) pick = VEC_W'(i);
        end
    end

    // top-of-stack view; zero when the stack is empty
    always_comb begin
        top_pc  = '0;
        top_sup = 1'b0;
        top_ien = 1'b0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (depth_q == DEP_W'(i + 1)) begin
                top_pc  = spc_q[i];
                top_sup = ssup_q[i];
                top_ien = sien_q[i];
            end
        end
    end

    // FSM next state; a return beats a new interrupt for one cycle
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        take    = 1'b0;
        pop     = ret_i && (depth_q != '0) && (state_q == IRQ_IDLE);
        case (state_q)
            IRQ_IDLE: begin
                if (!pop && ien_i && (|req) &&
                    (depth_q < DEP_W'(NEST_DEPTH))) begin
                    state_d = IRQ_TAKE;
                    vec_d   = pick;
                end
            end
            IRQ_TAKE: begin
                take    = 1'b1;
                state_d = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    // pending latch, stack and depth next state; push beats a TOS write
    always_comb begin
        push_pc = pc_ie_i  ? tgt_i :
                  pc_inc_i ? pc_i + DATA_W'(1) : pc_i;
        clr     = clr_i;
        for (int i = 0; i < IRQ_N; i++) begin
            if (take && (vec_q == VEC_W'(i))) clr[i] = 1'b1;
        end
        pend_d  = (pend_q & ~clr) | (irq_i & ~prev_q);
        spc_d   = spc_q;
        ssup_d  = ssup_q;
        sien_d  = sien_q;
        depth_d = depth_q;
        if (take) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (depth_q == DEP_W'(i)) begin
                    spc_d[i]  = push_pc;
                    ssup_d[i] = sup_i;
                    sien_d[i] = ien_i;
                end
            end
            depth_d = depth_q + DEP_W'(1);
        end else begin
            if (tos_we_i) begin
                for (int i = 0; i < NEST_DEPTH; i++) begin
                    if (depth_q == DEP_W'(i + 1)) spc_d[i] = tgt_i;
                end
            end
            if (pop) depth_d = depth_q - DEP_W'(1);
        end
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IRQ_IDLE;
            prev_q  <= '0;
            pend_q  <= '0;
            vec_q   <= '0;
            depth_q <= '0;
            ssup_q  <= '0;
            sien_q  <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) spc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= irq_i;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
            depth_q <= depth_d;
            ssup_q  <= ssup_d;
            sien_q  <= sien_d;
            spc_q   <= spc_d;
        end
    end

    assign pend_o    = pend_q;
    assign depth_o   = depth_q;
    assign ret_pc_o  = top_pc;
    assign take_o    = take;
    assign vec_o     = vec_q;
    assign pop_o     = pop;
    assign pop_sup_o = top_sup;
    assign pop_ien_o = top_ien;

endmodule

// File: rtl/sregs_mc.sv
// pcpu special-register block: MODE, boot latch, ALU flags,
// page table translation and the nested interrupt controller.
module sregs_mc
    import sregs_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PAGE_BITS  = 4,
    parameter int PHYS_W     = 20,
    parameter int IRQ_N      = 4,
    parameter int NEST_DEPTH = 2
) (
    input logic       clk,
    input logic       rst,
    sregs_mc_if.slave bus
);

    localparam int FRAME_W = PHYS_W - DATA_W + PAGE_BITS;
    localparam int NPAGE   = 1 << PAGE_BITS;
    localparam int OFF_W   = DATA_W - PAGE_BITS;
    localparam int VEC_W   = vec_w(IRQ_N);
    localparam int DEP_W   = $clog2(NEST_DEPTH + 1);

    logic [MODE_W-1:0]  mode_q, mode_d;
    logic               bootbuf_q, bootbuf_d;
    logic               boot_q, boot_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic [IRQ_N-1:0]   mask_q, mask_d;
    logic [FRAME_W-1:0] frame_q [NPAGE];
    logic [FRAME_W-1:0] frame_d [NPAGE];

    logic               sup;
    logic [DATA_W-1:0]  page_off;
    logic               is_page;
    logic [PAGE_BITS-1:0] page_idx;
    logic               wr_mode, wr_boot, wr_tos, wr_flags;
    logic               wr_mask, wr_pend, wr_page;
    logic [IRQ_N-1:0]   pend_clr;
    logic [DATA_W-1:0]  rd;
    logic [PAGE_BITS-1:0] xl_page;

    logic [IRQ_N-1:0]   pend;
    logic [DEP_W-1:0]   depth;
    logic [DATA_W-1:0]  ret_pc;
    logic               take;
    logic [VEC_W-1:0]   vec;
    logic               pop;
    logic               pop_sup;
    logic               pop_ien;

    assign sup      = mode_q[MODE_SUP];
    assign page_off = bus.sr_sel - DATA_W'(SR_PAGE_BASE);
    assign is_page  = (bus.sr_sel >= DATA_W'(SR_PAGE_BASE)) &&
                      (page_off < DATA_W'(NPAGE));
    assign page_idx = page_off[PAGE_BITS-1:0];
    assign pend_clr = wr_pend ? bus.sr_in[IRQ_N-1:0] : '0;

    // write strobe decode; privileged targets need SUP
    always_comb begin
        wr_mode  = 1'b0;
        wr_boot  = 1'b0;
        wr_tos   = 1'b0;
        wr_flags = 1'b0;
        wr_mask  = 1'b0;
        wr_pend  = 1'b0;
        wr_page  = 1'b0;
        if (bus.sr_ie) begin
            case (bus.sr_sel)
                DATA_W'(SR_MODE):  wr_mode  = sup;
                DATA_W'(SR_BOOT):  wr_boot  = 1'b1;
                DATA_W'(SR_IRQPC): wr_tos   = sup;
                DATA_W'(SR_FLAGS): wr_flags = 1'b1;
                DATA_W'(SR_MASK):  wr_mask  = 1'b1;
                DATA_W'(SR_PEND):  wr_pend  = 1'b1;
                default:           wr_page  = is_page && sup;
            endcase
        end
    end

    // combinational read mux; unmapped selects read zero
    always_comb begin
        rd = '0;
        case (bus.sr_sel)
            DATA_W'(SR_MODE):  rd = DATA_W'(mode_q);
            DATA_W'(SR_BOOT):  rd = DATA_W'(bootbuf_q);
            DATA_W'(SR_IRQPC): rd = ret_pc;
            DATA_W'(SR_FLAGS): rd = DATA_W'(flags_q);
            DATA_W'(SR_MASK):  rd = DATA_W'(mask_q);
            DATA_W'(SR_PEND):  rd = DATA_W'(pend);
            DATA_W'(SR_DEPTH): rd = DATA_W'(depth);
            default: begin
                if (is_page) rd = DATA_W'(frame_q[page_idx]);
            end
        endcase
    end

    irq_ctl #(
        .DATA_W     (DATA_W),
        .IRQ_N      (IRQ_N),
        .NEST_DEPTH (NEST_DEPTH),
        .VEC_W      (VEC_W),
        .DEP_W      (DEP_W)
    ) u_irq (
        .clk       (clk),
        .rst       (rst),
        .irq_i     (bus.irq_in),
        .mask_i    (mask_q),
        .clr_i     (pend_clr),
        .ien_i     (mode_q[MODE_IRQEN]),
        .sup_i     (sup),
        .pc_i      (bus.pc_in),
        .pc_ie_i   (bus.pc_ie),
        .pc_inc_i  (bus.pc_inc),
        .tgt_i     (bus.sr_in),
        .ret_i     (bus.irq_ret),
        .tos_we_i  (wr_tos),
        .pend_o    (pend),
        .depth_o   (depth),
        .ret_pc_o  (ret_pc),
        .take_o    (take),
        .vec_o     (vec),
        .pop_o     (pop),
        .pop_sup_o (pop_sup),
        .pop_ien_o (pop_ien)
    );

    // register next state; take/return override SUP and IRQEN
    always_comb begin
        mode_d    = mode_q;
        bootbuf_d = bootbuf_q;
        boot_d    = boot_q;
        flags_d   = flags_q;
        mask_d    = mask_q;
        frame_d   = frame_q;
        if (wr_mode) mode_d = bus.sr_in[MODE_W-1:0];
        if (take) begin
            mode_d[MODE_SUP]   = 1'b1;
            mode_d[MODE_IRQEN] = 1'b0;
        end else if (pop) begin
            mode_d[MODE_SUP]   = pop_sup;
            mode_d[MODE_IRQEN] = pop_ien;
        end
        if (wr_boot) bootbuf_d = bus.sr_in[0];
        if (bus.boot_commit) boot_d = bootbuf_q;
        if (bus.alu_flags_ie) flags_d = bus.alu_flags_in;
        else if (wr_flags)    flags_d = bus.sr_in[FLAGS_W-1:0];
        if (wr_mask) mask_d = bus.sr_in[IRQ_N-1:0];
        if (wr_page) frame_d[page_idx] = bus.sr_in[FRAME_W-1:0];
    end

    // state registers; page table resets to identity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_W'(1);
            bootbuf_q <= 1'b1;
            boot_q    <= 1'b1;
            flags_q   <= '0;
            mask_q    <= '1;
            for (int i = 0; i < NPAGE; i++) frame_q[i] <= FRAME_W'(i);
        end else begin
            mode_q    <= mode_d;
            bootbuf_q <= bootbuf_d;
            boot_q    <= boot_d;
            flags_q   <= flags_d;
            mask_q    <= mask_d;
            frame_q   <= frame_d;
        end
    end

    assign xl_page = bus.addr_in[DATA_W-1 -: PAGE_BITS];

    assign bus.addr_out = mode_q[MODE_PAGEOFF] ?
                          PHYS_W'(bus.addr_in) :
                          {frame_q[xl_page], bus.addr_in[OFF_W-1:0]};

    assign bus.sr_out         = rd;
    assign bus.irq_take       = take;
    assign bus.irq_vec        = vec;
    assign bus.ret_pc         = ret_pc;
    assign bus.boot_mode      = boot_q;
    assign bus.instr_mem_over = mode_q[MODE_INA];
    assign bus.irq_en         = mode_q[MODE_IRQEN];
    assign bus.alu_flags      = flags_q;

endmodule

// File: tb/tb_sregs_mc.sv
// Directed bench for sregs_mc with a per-cycle behavioural model.
module tb_sregs_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sregs_mc_if #(.DATA_W(16), .PHYS_W(20), .IRQ_N(4)) bus ();

    sregs_mc #(
        .DATA_W(16), .PAGE_BITS(4), .PHYS_W(20),
        .IRQ_N(4), .NEST_DEPTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] pc;
        logic        sup;
        logic        ien;
    } ent_t;

    logic [3:0] m_mode;
    logic       m_bootbuf, m_boot;
    logic [4:0] m_flags;
    logic [3:0] m_mask, m_pend, m_prev;
    logic [7:0] m_frame [16];
    ent_t       stk [$];
    logic       m_take;
    int         m_vec;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic m_reset();
        m_mode = 4'h1; m_bootbuf = 1'b1; m_boot = 1'b1;
        m_flags = '0; m_mask = 4'hF; m_pend = '0; m_prev = '0;
        for (int i = 0; i < 16; i++) m_frame[i] = 8'(i);
        stk.delete();
        m_take = 1'b0; m_vec = 0;
    endtask

    task automatic m_step();
        logic [3:0] pm;
        logic [3:0] clr;
        logic       ret_ok, qual, sup, ien, obuf;
        logic [15:0] s, d, rpc;
        ent_t e;
        int v;
        pm = m_pend & m_mask;
        sup = m_mode[0];
        ien = m_mode[2];
        obuf = m_bootbuf;
        ret_ok = bus.irq_ret && (stk.size() > 0) && !m_take;
        qual = !m_take && !ret_ok && ien && (pm != 0) && (stk.size() < 2);
        v = lowest(pm);
        clr = '0;
        s = bus.sr_sel;
        d = bus.sr_in;
        if (bus.sr_ie) begin
            if (s == 1 && sup) m_mode = d[3:0];
            if (s == 2) m_bootbuf = d[0];
            if (s == 3 && sup && !m_take && stk.size() > 0)
                stk[stk.size()-1].pc = d;
            if (s == 4 && !bus.alu_flags_ie) m_flags = d[4:0];
            if (s == 5) m_mask = d[3:0];
            if (s == 6) clr = d[3:0];
            if (s >= 16 && s < 32 && sup) m_frame[s-16] = d[7:0];
        end
        if (bus.alu_flags_ie) m_flags = bus.alu_flags_in;
        if (bus.boot_commit) m_boot = obuf;
        if (m_take) begin
            rpc = bus.pc_ie ? d : bus.pc_inc ? bus.pc_in + 16'd1 : bus.pc_in;
            e.pc = rpc; e.sup = sup; e.ien = ien;
            stk.push_back(e);
            clr[m_vec] = 1'b1;
            m_mode[0] = 1'b1;
            m_mode[2] = 1'b0;
        end else if (ret_ok) begin
            e = stk.pop_back();
            m_mode[0] = e.sup;
            m_mode[2] = e.ien;
        end
        m_pend = (m_pend & ~clr) | (bus.irq_in & ~m_prev);
        m_prev = bus.irq_in;
        m_take = qual;
        if (qual) m_vec = v;
    endtask

    function automatic logic [15:0] m_top();
        if (stk.size() == 0) return 16'h0;
        return stk[stk.size()-1].pc;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] s);
        case (s)
            16'd1: return {12'h0, m_mode};
            16'd2: return {15'h0, m_bootbuf};
            16'd3: return m_top();
            16'd4: return {11'h0, m_flags};
            16'd5: return {12'h0, m_mask};
            16'd6: return {12'h0, m_pend};
            16'd7: return 16'(stk.size());
            default: begin
                if (s >= 16 && s < 32) return {8'h0, m_frame[s-16]};
                return 16'h0;
            end
        endcase
    endfunction

    function automatic logic [19:0] m_addr(input logic [15:0] a);
        if (m_mode[3]) return {4'h0, a};
        return {m_frame[a[15:12]], a[11:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    always @(negedge clk) begin
        chk("sr_out", bus.sr_out, m_read(bus.sr_sel));
        chk("addr_out", bus.addr_out, m_addr(bus.addr_in));
        chk("ret_pc", bus.ret_pc, m_top());
        chk("irq_take", bus.irq_take, m_take);
        if (m_take) chk("irq_vec", bus.irq_vec, 32'(m_vec));
        chk("boot_mode", bus.boot_mode, m_boot);
        chk("ina", bus.instr_mem_over, m_mode[1]);
        chk("irq_en", bus.irq_en, m_mode[2]);
        chk("alu_flags", bus.alu_flags, m_flags);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [15:0] s, input logic [15:0] d);
        step();
        bus.sr_ie = 1'b1; bus.sr_sel = s; bus.sr_in = d;
        step();
        bus.sr_ie = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [15:0] s,
                      input logic [15:0] e);
        bus.sr_sel = s;
        #1;
        chk(nm, bus.sr_out, e);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic ret_pulse();
        step();
        bus.irq_ret = 1'b1;
        step();
        bus.irq_ret = 1'b0;
    endtask

    task automatic wait_take(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.irq_take;
        end
    endtask

    bit got;

    initial begin
        bus.sr_ie = 0; bus.sr_sel = 0; bus.sr_in = 0;
        bus.boot_commit = 0; bus.irq_in = 0; bus.pc_in = 0;
        bus.pc_ie = 0; bus.pc_inc = 0; bus.irq_ret = 0;
        bus.alu_flags_in = 0; bus.alu_flags_ie = 0;
        bus.addr_in = 16'h3ABC;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        rd("rst_mode", 16'd1, 16'h0001);
        rd("rst_boot", 16'd2, 16'h0001);
        rd("rst_mask", 16'd5, 16'h000F);
        rd("rst_pend", 16'd6, 16'h0000);
        rd("rst_depth", 16'd7, 16'h0000);
        chk("rst_addr", bus.addr_out, 20'h03ABC);
        chk("rst_take", bus.irq_take, 1'b0);

        wr(16'h13, 16'h005A);
        chk("page_map", bus.addr_out, 20'h5AABC);
        wr(16'd1, 16'h0009);
        chk("pageoff", bus.addr_out, 20'h03ABC);
        rd("mode9", 16'd1, 16'h0009);
        wr(16'd1, 16'h0003);
        chk("ina_on", bus.instr_mem_over, 1'b1);
        wr(16'd2, 16'h0000);
        chk("boot_hold", bus.boot_mode, 1'b1);
        step(); bus.boot_commit = 1'b1;
        step(); bus.boot_commit = 1'b0;
        chk("boot_commit", bus.boot_mode, 1'b0);
        step();
        bus.sr_ie = 1; bus.sr_sel = 16'd4; bus.sr_in = 16'h0015;
        bus.alu_flags_ie = 1; bus.alu_flags_in = 5'h0A;
        step();
        bus.sr_ie = 0; bus.alu_flags_ie = 0;
        chk("flags_prio", bus.alu_flags, 5'h0A);
        wr(16'd4, 16'h0015);
        chk("flags_wr", bus.alu_flags, 5'h15);
        wr(16'd1, 16'h0000);
        wr(16'h13, 16'h0011);
        chk("page_nosup", bus.addr_out, 20'h5AABC);
        wr(16'd1, 16'h0005);
        rd("mode_nosup", 16'd1, 16'h0000);
        rd("unmapped", 16'h0020, 16'h0000);
        rd("frame13", 16'h0013, 16'h005A);

        do_reset();
        wr(16'd1, 16'h0004);
        bus.pc_in = 16'h0100; bus.pc_inc = 1'b1;
        bus.irq_in = 4'b0110;
        wait_take(got);
        chk("take1_seen", got, 1'b1);
        chk("take1_vec", bus.irq_vec, 2'd1);
        step();
        chk("take1_retpc", bus.ret_pc, 16'h0101);
        rd("take1_mode", 16'd1, 16'h0001);
        rd("take1_pend", 16'd6, 16'h0004);
        rd("take1_depth", 16'd7, 16'h0001);

        bus.pc_in = 16'h0200; bus.pc_inc = 1'b0;
        wr(16'd1, 16'h0005);
        wait_take(got);
        chk("take2_seen", got, 1'b1);
        chk("take2_vec", bus.irq_vec, 2'd2);
        step();
        chk("take2_retpc", bus.ret_pc, 16'h0200);
        rd("take2_depth", 16'd7, 16'h0002);
        bus.irq_in = 4'b1110;
        wr(16'd1, 16'h0005);
        repeat (5) step();
        rd("blk_pend", 16'd6, 16'h0008);
        rd("blk_depth", 16'd7, 16'h0002);
        wr(16'd6, 16'h0008);
        rd("clr_pend", 16'd6, 16'h0000);
        wr(16'd1, 16'h0001);
        ret_pulse();
        chk("ret1_pc", bus.ret_pc, 16'h0101);
        rd("ret1_mode", 16'd1, 16'h0005);
        rd("ret1_depth", 16'd7, 16'h0001);
        repeat (3) step();
        ret_pulse();
        chk("ret2_pc", bus.ret_pc, 16'h0000);
        rd("ret2_mode", 16'd1, 16'h0004);
        ret_pulse();
        rd("ret3_depth", 16'd7, 16'h0000);
        rd("ret3_mode", 16'd1, 16'h0004);

        wr(16'd5, 16'h000E);
        bus.irq_in = 4'b1111;
        repeat (4) step();
        rd("mask_pend", 16'd6, 16'h0001);
        rd("mask_depth", 16'd7, 16'h0000);
        bus.irq_in = 4'b1110;
        wr(16'd6, 16'h0001);
        rd("w1c_pend", 16'd6, 16'h0000);
        step();
        bus.irq_in = 4'b1111;
        bus.sr_ie = 1; bus.sr_sel = 16'd6; bus.sr_in = 16'h0001;
        step();
        bus.sr_ie = 0;
        rd("setwins", 16'd6, 16'h0001);

        wr(16'd5, 16'h000F);
        wait_take(got);
        chk("take3_seen", got, 1'b1);
        chk("take3_vec", bus.irq_vec, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_take_pulse", bus.irq_take, 1'b0);
        rd("rst_take_depth", 16'd7, 16'h0000);
        rd("rst_take_mode", 16'd1, 16'h0001);
        rd("rst_take_pend", 16'd6, 16'h0000);
        chk("rst_take_retpc", bus.ret_pc, 16'h0000);
        step(); step();
        rst = 1'b0;
        repeat (3) step();
        rd("post_depth", 16'd7, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sregs_mc.md
# sregs_mc

Parametrised next-generation special-register block for the pcpu core. It holds processor mode, boot-mode latch, ALU flags, the memory page table, and a multi-line prioritised interrupt controller with a nested saved-PC stack. It sits beside the decoder and PC unit: it maps 16-bit logical addresses to physical, and tells the PC unit when to take an interrupt or return from one.

## Interface
Parameters:
- DATA_W, 16, register/data/PC width
- PAGE_BITS, 4, logical page-index bits; 2^PAGE_BITS page entries
- PHYS_W, 20, physical address width; frame width FRAME_W = PHYS_W − DATA_W + PAGE_BITS (must be ≥1)
- IRQ_N, 4, interrupt request lines; line 0 highest priority
- NEST_DEPTH, 2, saved-PC stack depth (≥1)

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- sr_ie  in  1  special-register write strobe
- sr_sel  in  DATA_W  register select
- sr_in  in  DATA_W  write data / branch target
- sr_out  out  DATA_W  combinational read data
- boot_commit  in  1  decoder pulse: copy boot buffer to boot_mode
- irq_in  in  IRQ_N  level-sensitive request lines
- pc_in  in  DATA_W  current PC
- pc_ie, pc_inc  in  1  PC load / increment this cycle
- irq_take  out  1  one-cycle pulse: PC unit jumps to vector
- irq_vec  out  clog2(IRQ_N) (min 1)  line being taken, valid with irq_take
- irq_ret  in  1  decoder pulse: return from interrupt
- ret_pc  out  DATA_W  top-of-stack saved PC
- boot_mode, instr_mem_over, irq_en  out  1  mode outputs
- alu_flags_in  in  5; alu_flags_ie  in  1; alu_flags  out  5
- addr_in  in  DATA_W; addr_out  out  PHYS_W  translated address

## Operation
- Register map (write when sr_ie): 1 MODE[3:0] {PAGEOFF, IRQEN, INA, SUP}, writable only while SUP=1. 2 boot buffer bit0. 3 top-of-stack PC (SUP only). 4 ALU flags. 5 IRQ mask, bits [IRQ_N-1:0]; 1 = enabled. 6 pending (read-only; write 1 to clear a latched request). 7 stack depth (read-only). 0x10 + i: page frame i (SUP only). Unmapped selects read 0; writes to them are ignored.
- Reset values: MODE=0001, boot buffer=1, boot_mode=1, mask=all 1, pending=0, stack empty, alu_flags=0, irq_take=0, ret_pc=0. Page table is reset to identity: frame i = i zero-extended.
- Pending: bit set on the rising edge of irq_in[i]; set wins over a same-cycle clear.
- IRQ FSM states:
  - IDLE: when IRQEN=1, (pending & mask)≠0 and depth<NEST_DEPTH, go to TAKE.
  - TAKE (1 cycle): assert irq_take with irq_vec = the lowest set index. Push the return PC: sr_in if pc_ie, else pc_in+1 if pc_inc, else pc_in. Push the current SUP and IRQEN along with it. Clear that pending bit. Set SUP=1 and IRQEN=0. Return to IDLE.
- irq_ret with depth>0 pops the stack and restores SUP and IRQEN. irq_ret with an empty stack is ignored.
- When irq_ret and an interrupt qualify in the same cycle, the return happens first and the interrupt is evaluated the next cycle.
- Translation: when PAGEOFF=1, addr_out = zero-extend(addr_in). Otherwise addr_out = {frame[addr_in top PAGE_BITS], addr_in low DATA_W−PAGE_BITS bits}.
- ALU flags: alu_flags_ie has priority over a register-4 write in the same cycle.

## Timing
- sr_out, addr_out and ret_pc are combinational. All writes become visible the cycle after the strobe.
- Interrupt latency: the rising edge is sampled at edge N, pending is visible at N+1, and irq_take is asserted during the cycle after N+1.
- A stack push and a register-3 write in the same cycle: the push wins.
- Reset mid-TAKE aborts the take; all state returns to reset values asynchronously.

## Structure
- Shared package `sregs_pkg`: SR_MODE, SR_BOOT, SR_IRQPC, SR_FLAGS, SR_MASK, SR_PEND, SR_DEPTH and SR_PAGE_BASE constants; MODE bit indices.
- One sub-module `irq_ctl`: pending latch, priority encoder, FSM and PC stack. The page table and mode registers stay in the top module.

## Test plan
- Reset, then read 1/2/5/6/7 → 0x0001/0x0001/0x000F/0/0; addr_in 0x3ABC → addr_out 0x03ABC.
- With SUP=1, write frame 0x13 = 0x5A → 0x3ABC maps to 0x5AABC. Clear SUP, write frame 0x13 = 0x11 → unchanged.
- With IRQEN=1, raise irq_in[2] and irq_in[1] together at PC 0x0100 with pc_inc → irq_take with vec=1, ret_pc=0x0101, SUP=1, IRQEN=0, pending=0x4.
- Nested case with NEST_DEPTH=2: re-enable, take line 2, then a third request is blocked at depth 2. irq_ret twice → PCs popped in LIFO order and mode restored.
- Mask line 0 → requests on line 0 stay pending and are not taken. Write 1 to pending bit 0 in the same cycle as a new edge → bit stays set.
- Assert rst during TAKE → depth=0, MODE=0001, irq_take=0.
